// File: rtl/sha_ctrl_pkg.sv
// Shared constants and types for the SHA-256 miner control path:
// FSM state encoding, round count and the block phase codes seen by the H registers.
package sha_ctrl_pkg;

  localparam int SHA_ROUNDS = 64;
  localparam int ROUND_W    = $clog2(SHA_ROUNDS);
  localparam int NONCE_W    = 32;

  localparam logic [1:0] BLK_IDLE   = 2'd0;
  localparam logic [1:0] BLK_HDR1   = 2'd1;
  localparam logic [1:0] BLK_HDR2   = 2'd2;
  localparam logic [1:0] BLK_DIGEST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FF,
    ST_CHECK
  } state_t;

  // Chunk order is HDR1 -> HDR2 -> DIGEST; the caller decides what follows DIGEST.
  function automatic logic [1:0] next_block(input logic [1:0] blk);
    return blk + 2'd1;
  endfunction

endpackage

// File: rtl/sha_miner_sequencer_if.sv
// Job/control bundle between a host (master) and the miner sequencer (slave).
// Carries job launch/abort, the compare result and the per-round control strobes.
interface sha_miner_sequencer_if;
  import sha_ctrl_pkg::*;

  logic               start;
  logic               abort;
  logic [NONCE_W-1:0] nonce_start;
  logic [NONCE_W-1:0] nonce_end;
  logic               hit;

  logic [1:0]         block;
  logic [ROUND_W-1:0] round;
  logic               w_load;
  logic               round_en;
  logic               ff_en;
  logic [NONCE_W-1:0] nonce;
  logic               busy;
  logic               done;
  logic               found;

  modport master (
    output start, abort, nonce_start, nonce_end, hit,
    input  block, round, w_load, round_en, ff_en, nonce, busy, done, found
  );

  modport slave (
    input  start, abort, nonce_start, nonce_end, hit,
    output block, round, w_load, round_en, ff_en, nonce, busy, done, found
  );

endinterface

// File: rtl/sha_miner_sequencer_round_ctr.sv
// Compression round counter: clears to 0, advances on en, flags the final round.
module sha_round_ctr
  import sha_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [ROUND_W-1:0] count,
  output logic               last
);

  logic [ROUND_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + ROUND_W'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == ROUND_W'(SHA_ROUNDS - 1));

endmodule

// File: rtl/sha_miner_sequencer.sv
// Sequences three 64-round SHA-256 chunks per nonce and checks the target result.
// Define NONCE_SWEEP_EN to sweep nonce_start..nonce_end until a hit; otherwise one nonce per job.
module sha_miner_sequencer
  import sha_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  sha_miner_sequencer_if.slave bus
);

  state_t             state_reg;
  logic [1:0]         block_reg;
  logic [NONCE_W-1:0] nonce_reg;
  logic               w_load_reg;
  logic               round_en_reg;
  logic               ff_en_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               found_reg;

  logic [ROUND_W-1:0] round_cnt;
  logic               round_last;
  logic               abort_act;
  logic               ctr_clr;
  logic               ctr_en;

  assign abort_act = bus.abort && (state_reg != ST_IDLE);

  // Counter only runs inside ROUND; it holds 63 through FF and drops to 0 on the way out.
  assign ctr_clr = (state_reg != ST_ROUND) || abort_act;
  assign ctr_en  = (state_reg == ST_ROUND) && !round_last;

  sha_round_ctr u_round_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .count (round_cnt),
    .last  (round_last)
  );

`ifdef NONCE_SWEEP_EN
  logic [NONCE_W-1:0] nonce_end_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_end_reg <= '0;
    end else if (state_reg == ST_IDLE && bus.start) begin
      nonce_end_reg <= bus.nonce_end;
    end
  end
`else
  logic unused_nonce_end;
  assign unused_nonce_end = ^bus.nonce_end;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      block_reg    <= BLK_IDLE;
      nonce_reg    <= '0;
      w_load_reg   <= 1'b0;
      round_en_reg <= 1'b0;
      ff_en_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      found_reg    <= 1'b0;
    end else begin
      w_load_reg   <= 1'b0;
      round_en_reg <= 1'b0;
      ff_en_reg    <= 1'b0;
      done_reg     <= 1'b0;

      if (abort_act) begin
        state_reg <= ST_IDLE;
        block_reg <= BLK_IDLE;
        busy_reg  <= 1'b0;
        found_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (bus.start) begin
              state_reg  <= ST_LOAD;
              block_reg  <= BLK_HDR1;
              nonce_reg  <= bus.nonce_start;
              found_reg  <= 1'b0;
              busy_reg   <= 1'b1;
              w_load_reg <= 1'b1;
            end
          end

          ST_LOAD: begin
            state_reg    <= ST_ROUND;
            round_en_reg <= 1'b1;
          end

          ST_ROUND: begin
            if (round_last) begin
              state_reg <= ST_FF;
              ff_en_reg <= 1'b1;
            end else begin
              round_en_reg <= 1'b1;
            end
          end

          ST_FF: begin
            if (block_reg == BLK_DIGEST) begin
              state_reg <= ST_CHECK;
              block_reg <= BLK_IDLE;
            end else begin
              state_reg  <= ST_LOAD;
              block_reg  <= next_block(block_reg);
              w_load_reg <= 1'b1;
            end
          end

          ST_CHECK: begin
`ifdef NONCE_SWEEP_EN
            // End test comes before the increment so nonce_end = all-ones never wraps.
            if (bus.hit || nonce_reg == nonce_end_reg) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              found_reg <= bus.hit;
            end else begin
              nonce_reg  <= nonce_reg + NONCE_W'(1);
              state_reg  <= ST_LOAD;
              block_reg  <= BLK_HDR1;
              w_load_reg <= 1'b1;
            end
`else
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            found_reg <= bus.hit;
`endif
          end

          default: begin
            state_reg <= ST_IDLE;
            block_reg <= BLK_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.block    = block_reg;
  assign bus.round    = round_cnt;
  assign bus.w_load   = w_load_reg;
  assign bus.round_en = round_en_reg;
  assign bus.ff_en    = ff_en_reg;
  assign bus.nonce    = nonce_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.found    = found_reg;

endmodule
